univ_reg: RTL and testbench

- Parametrised universal register. Successor to the fixed 4-bit load register.
- Adds generic width, parallel load, logical shift and rotate in both directions, synchronous clear and hold.
- Tracks shifts since the last load and flags when a full word has been serialised.
- Used as a parallel/serial converter and general storage element in the memory-elements library.

---
 rtl/univ_reg.sv | 106 ++++++++++
 tb/tb_univ_reg.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/univ_reg.sv
// Parametrised universal register: parallel load, logical shift and rotate in both
// directions, synchronous clear and hold, plus a saturating shift counter with word_done.
module univ_reg #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             word_done
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_ROL   = 3'b100,
        MODE_ROR   = 3'b101,
        MODE_CLEAR = 3'b110,
        MODE_RSVD  = 3'b111
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mode_e            mode_sel;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             word_done_q, word_done_d;
    logic             is_shift;

    assign mode_sel = mode_e'(mode);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        q_d         = q_q;
        cnt_d       = cnt_q;
        word_done_d = 1'b0;
        is_shift    = 1'b0;

        case (mode_sel)
            MODE_LOAD: begin
                q_d   = d;
                cnt_d = '0;
            end
            MODE_SHL: begin
                q_d      = {q_q[WIDTH-2:0], sin_l};
                is_shift = 1'b1;
            end
            MODE_SHR: begin
                q_d      = {sin_r, q_q[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            MODE_ROL: begin
                q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                is_shift = 1'b1;
            end
            MODE_ROR: begin
                q_d      = {q_q[0], q_q[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            MODE_CLEAR: begin
                q_d   = RESET_VAL;
                cnt_d = '0;
            end
            default: ; // hold, reserved and unknown modes keep state
        endcase

        // Pulse only on the WIDTH-1 -> WIDTH step; the counter saturates instead of wrapping.
        if (is_shift) begin
            word_done_d = (cnt_q == CNT_LAST);
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q         <= RESET_VAL;
            cnt_q       <= '0;
            word_done_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            word_done_q <= word_done_d;
        end
    end

    assign q         = q_q;
    assign sout_l    = q_q[WIDTH-1];
    assign sout_r    = q_q[0];
    assign shift_cnt = cnt_q;
    assign word_done = word_done_q;

endmodule

// File: tb/tb_univ_reg.sv
// Self-checking bench for univ_reg: a 4-bit and a 2-bit instance share mode and are
// compared every cycle against an arithmetic model, plus directed literal checks.
module tb_univ_reg;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] mode;
    logic [3:0] d;
    logic       sin_l, sin_r;

    logic [3:0] qa;
    logic       sla, sra, wda;
    logic [2:0] cnta;
    logic [1:0] qb;
    logic       slb, srb, wdb;
    logic [1:0] cntb;

    int checks = 0;
    int errors = 0;

    // Model state: A is WIDTH=4, RESET_VAL=1010, CNT_W=3; B is WIDTH=2, RESET_VAL=01, CNT_W=2.
    int ma_q, ma_cnt, mb_q, mb_cnt;
    bit ma_wd, mb_wd;

    always #5 clk = ~clk;

    univ_reg #(.WIDTH(4), .RESET_VAL(4'b1010), .CNT_W(3)) dut_a (
        .clk(clk), .reset(reset), .mode(mode), .d(d), .sin_l(sin_l), .sin_r(sin_r),
        .q(qa), .sout_l(sla), .sout_r(sra), .shift_cnt(cnta), .word_done(wda)
    );

    univ_reg #(.WIDTH(2), .RESET_VAL(2'b01), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .mode(mode), .d(d[1:0]), .sin_l(sin_l), .sin_r(sin_r),
        .q(qb), .sout_l(slb), .sout_r(srb), .shift_cnt(cntb), .word_done(wdb)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural step: registers as integers, shifts as multiply/divide by two.
    task automatic model_step(input int w, input int rv, input int cmax,
                              inout int mq, inout int mcnt, inout bit mwd,
                              input int md, input int dv, input bit sl, input bit sr);
        int  top;
        bit  shifted;
        top     = 1 << (w - 1);
        shifted = 1'b0;
        mwd     = 1'b0;
        case (md)
            1: begin mq = dv % (2 * top); mcnt = 0; end
            2: begin mq = (mq * 2) % (2 * top) + int'(sl); shifted = 1'b1; end
            3: begin mq = mq / 2 + (sr ? top : 0); shifted = 1'b1; end
            4: begin mq = (mq * 2) % (2 * top) + mq / top; shifted = 1'b1; end
            5: begin mq = mq / 2 + ((mq % 2) * top); shifted = 1'b1; end
            6: begin mq = rv; mcnt = 0; end
            default: ;
        endcase
        if (shifted) begin
            if (mcnt == w - 1) mwd = 1'b1;
            if (mcnt < cmax) mcnt++;
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ma_q = 'hA; ma_cnt = 0; ma_wd = 1'b0;
            mb_q = 1;   mb_cnt = 0; mb_wd = 1'b0;
        end else begin
            model_step(4, 'hA, 7, ma_q, ma_cnt, ma_wd, int'(mode), int'(d), sin_l, sin_r);
            model_step(2, 1,   3, mb_q, mb_cnt, mb_wd, int'(mode), int'(d), sin_l, sin_r);
        end
    end

    // Outputs only move on posedge or reset, so the falling edge is a stable sample point.
    always @(negedge clk) begin
        check("cmp_a_q",    32'(qa),   32'(ma_q));
        check("cmp_a_sl",   32'(sla),  32'(ma_q / 8));
        check("cmp_a_sr",   32'(sra),  32'(ma_q % 2));
        check("cmp_a_cnt",  32'(cnta), 32'(ma_cnt));
        check("cmp_a_wd",   32'(wda),  32'(ma_wd));
        check("cmp_b_q",    32'(qb),   32'(mb_q));
        check("cmp_b_sl",   32'(slb),  32'(mb_q / 2));
        check("cmp_b_sr",   32'(srb),  32'(mb_q % 2));
        check("cmp_b_cnt",  32'(cntb), 32'(mb_cnt));
        check("cmp_b_wd",   32'(wdb),  32'(mb_wd));
    end

    // Apply one operation; returns 1 time unit after the edge that consumes it.
    task automatic step(input logic [2:0] m, input logic [3:0] dv, input logic sl, input logic sr);
        @(negedge clk);
        #1;
        mode  = m;
        d     = dv;
        sin_l = sl;
        sin_r = sr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        mode  = 3'b001;
        d     = 4'b0101;
        sin_l = 1'b0;
        sin_r = 1'b0;

        // Reset held across edges, then asynchronous reset between edges
        repeat (3) @(posedge clk);
        #1;
        check("rst_q",    32'(qa),   32'hA);
        check("rst_cnt",  32'(cnta), 32'h0);
        check("rst_wd",   32'(wda),  32'h0);
        check("rst_b_q",  32'(qb),   32'h1);
        reset = 1'b1;
        step(3'b001, 4'b0101, 1'b0, 1'b0);
        check("load_0101", 32'(qa), 32'h5);
        #1 reset = 1'b0;
        #1 check("async_rst_q", 32'(qa), 32'hA);
        #1 reset = 1'b1;

        // Load then hold
        step(3'b001, 4'b0110, 1'b0, 1'b0);
        check("load_0110", 32'(qa), 32'h6);
        repeat (3) step(3'b000, 4'b1111, 1'b1, 1'b1);
        check("hold_q",   32'(qa),   32'h6);
        check("hold_cnt", 32'(cnta), 32'h0);

        // Serialise 1011 out of sout_r
        step(3'b001, 4'b1011, 1'b0, 1'b0);
        check("ser_sr0", 32'(sra), 32'h1);
        step(3'b011, 4'b0000, 1'b0, 1'b0);
        check("ser_sr1", 32'(sra), 32'h1);
        step(3'b011, 4'b0000, 1'b0, 1'b0);
        check("ser_sr2", 32'(sra), 32'h0);
        step(3'b011, 4'b0000, 1'b0, 1'b0);
        check("ser_sr3", 32'(sra), 32'h1);
        check("ser_wd3", 32'(wda), 32'h0);
        step(3'b011, 4'b0000, 1'b0, 1'b0);
        check("ser_q",   32'(qa),   32'h0);
        check("ser_cnt", 32'(cnta), 32'h4);
        check("ser_wd4", 32'(wda),  32'h1);

        // Rotate left a single one through the word and beyond
        step(3'b001, 4'b1000, 1'b0, 1'b0);
        step(3'b100, 4'b0000, 1'b0, 1'b0);
        check("rol_1", 32'(qa), 32'h1);
        step(3'b100, 4'b0000, 1'b0, 1'b0);
        check("rol_2", 32'(qa), 32'h2);
        step(3'b100, 4'b0000, 1'b0, 1'b0);
        check("rol_3", 32'(qa), 32'h4);
        step(3'b100, 4'b0000, 1'b0, 1'b0);
        check("rol_4",    32'(qa),  32'h8);
        check("rol_4_wd", 32'(wda), 32'h1);
        step(3'b100, 4'b0000, 1'b0, 1'b0);
        check("rol_5",     32'(qa),   32'h1);
        check("rol_5_cnt", 32'(cnta), 32'h5);
        check("rol_5_wd",  32'(wda),  32'h0);

        // Shift left with serial input; the 2-bit instance also saturates here
        step(3'b001, 4'b0000, 1'b0, 1'b0);
        step(3'b010, 4'b0000, 1'b1, 1'b0);
        check("shl_1", 32'(qa), 32'h1);
        step(3'b010, 4'b0000, 1'b0, 1'b0);
        check("shl_2",     32'(qa),  32'h2);
        check("shl_b_wd",  32'(wdb), 32'h1);
        step(3'b010, 4'b0000, 1'b1, 1'b0);
        check("shl_3",     32'(qa),   32'h5);
        check("shl_b_q",   32'(qb),   32'h1);
        check("shl_b_cnt", 32'(cntb), 32'h3);

        // Saturation, clear and reserved mode
        repeat (10) step(3'b101, 4'b0000, 1'b0, 1'b0);
        check("sat_cnt", 32'(cnta), 32'h7);
        check("sat_wd",  32'(wda),  32'h0);
        step(3'b110, 4'b0000, 1'b0, 1'b0);
        check("clr_q",   32'(qa),   32'hA);
        check("clr_cnt", 32'(cnta), 32'h0);
        step(3'b111, 4'b0101, 1'b1, 1'b1);
        check("rsvd_q",   32'(qa),   32'hA);
        check("rsvd_cnt", 32'(cnta), 32'h0);

        // Randomised phase, shift-heavy so word_done and saturation recur
        for (int i = 0; i < 600; i++) begin
            int r;
            logic [2:0] m;
            r = int'($urandom_range(0, 9));
            if (r < 6)       m = 3'(2 + (r % 4));
            else if (r == 6) m = 3'b001;
            else if (r == 7) m = 3'b000;
            else if (r == 8) m = 3'b110;
            else             m = 3'b111;
            step(m, 4'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b0;
                #2 reset = 1'b1;
            end
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
